// File: rtl/mdu_iter_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_iter_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state_e;

    function automatic logic is_div_op(mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic op_a_signed(mdu_op_e op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_b_signed(mdu_op_e op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between decode and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            kill;
    logic [6:0]      opcode;
    logic [2:0]      Funct3;
    logic [6:0]      Funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            is_mdu;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, opcode, Funct3, Funct7, rs1, rs2,
        input  is_mdu, busy, done, result
    );

    modport slave (
        input  start, kill, opcode, Funct3, Funct7, rs1, rs2,
        output is_mdu, busy, done, result
    );
endinterface

// File: rtl/mdu_iter_sign_fix.sv
// Sign handling around the unsigned core: operand magnitudes on the way in,
// result selection and conditional negation on the way out.
module mdu_sign_fix
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  mdu_op_e         op_in,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            neg,
    input  mdu_op_e         op_out,
    input  logic            neg_out,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] res
);
    logic              a_neg;
    logic              b_neg;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        a_neg = op_a_signed(op_in) && a[XLEN-1];
        b_neg = op_b_signed(op_in) && b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        // Remainder follows the dividend sign; everything else the sign product.
        neg   = (op_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        prod = {hi, lo};
        if (neg_out) begin
            prod = -prod;
        end
        res = '0;
        case (op_out)
            MDU_MUL:                         res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               res = neg_out ? -lo : lo;
            default:                         res = neg_out ? -hi : hi;
        endcase
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle in CALC.
// Define MDU_FAST_MUL_EN for single-cycle multiplies (divides still iterate).
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e         op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] shr_q, shr_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;

    mdu_op_e         op_in;
    logic            is_mdu;
    logic            accept;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_in;
    logic [XLEN-1:0] res_fix;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_trial;
    logic [XLEN-1:0] div_diff;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    assign op_in  = mdu_op_e'(bus.Funct3);
    assign is_mdu = (bus.opcode == OPC_RTYPE) && (bus.Funct7 == F7_MULDIV);
    assign accept = (state_q == IDLE) && bus.start && is_mdu && !bus.kill;

    // Output side sees the post-step values so the final iteration lands in result.
    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op_in   (op_in),
        .a       (bus.rs1),
        .b       (bus.rs2),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .neg     (neg_in),
        .op_out  (op_q),
        .neg_out (neg_q),
        .hi      (step_hi),
        .lo      (step_lo),
        .res     (res_fix)
    );

    // acc/shr double as product hi/lo for multiply and remainder/quotient for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opb_q} : '0);
        div_trial = {acc_q, shr_q[XLEN-1]};
        div_diff  = div_trial[XLEN-1:0] - opb_q;
        step_hi   = mul_sum[XLEN:1];
        step_lo   = {mul_sum[0], shr_q[XLEN-1:1]};
        if (is_div_op(op_q)) begin
            if (div_trial >= {1'b0, opb_q}) begin
                step_hi = div_diff;
                step_lo = {shr_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_trial[XLEN-1:0];
                step_lo = {shr_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        div_zero    = (bus.rs2 == '0);
        div_ovf     = (op_in inside {MDU_DIV, MDU_REM}) &&
                      (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        special_res = '0;
        case (op_in)
            MDU_DIV, MDU_DIVU: special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
            MDU_REM, MDU_REMU: special_res = div_zero ? bus.rs1 : '0;
            default:           special_res = '0;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a;
    logic signed [2*XLEN-1:0] fast_b;
    logic signed [2*XLEN-1:0] fast_prod;

    // 33x33 signed multiply expressed on sign/zero-extended operands.
    always_comb begin
        fast_a    = {{XLEN{op_a_signed(op_in) & bus.rs1[XLEN-1]}}, bus.rs1};
        fast_b    = {{XLEN{op_b_signed(op_in) & bus.rs2[XLEN-1]}}, bus.rs2};
        fast_prod = fast_a * fast_b;
        fast_res  = (op_in == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        fast_hit  = !is_div_op(op_in);
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        shr_d    = shr_q;
        opb_d    = opb_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = op_in;
                    neg_d = neg_in;
                    cnt_d = '0;
                    acc_d = '0;
                    if (is_div_op(op_in) && (div_zero || div_ovf)) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else if (fast_hit) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                        shr_d   = is_div_op(op_in) ? a_mag : b_mag;
                        opb_d   = is_div_op(op_in) ? b_mag : a_mag;
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_hi;
                    shr_d = step_lo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = res_fix;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MDU_MUL;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            shr_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            shr_q    <= shr_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign bus.is_mdu = is_mdu;
    assign bus.busy   = (state_q == CALC) || (state_q == DONE);
    assign bus.done   = (state_q == DONE) && !bus.kill;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter with a cycle-level reference model checked every cycle.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_iter_if #(.XLEN(32)) bus ();

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        if (f3[2]) begin
            if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
            return 33;
        end
        return MUL_LAT;
    endfunction

    // Model: idle/active window, pending result, visible result.
    bit          m_active = 1'b0;
    int          m_acc = 0;
    int          m_done_cyc = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_result = '0;

    always @(negedge clk) begin
        logic exp_busy, exp_done, exp_mdu;
        logic [31:0] exp_res;
        exp_mdu = (bus.opcode == 7'b0110011) && (bus.Funct7 == 7'b0000001);
        chk("is_mdu", {31'b0, bus.is_mdu}, {31'b0, exp_mdu});
        if (rst) begin
            m_active = 1'b0;
            m_result = '0;
            chk("busy_rst", {31'b0, bus.busy}, 32'd0);
            chk("done_rst", {31'b0, bus.done}, 32'd0);
            chk("result_rst", bus.result, 32'd0);
        end else begin
            exp_busy = m_active && (cyc > m_acc);
            exp_done = m_active && (cyc == m_done_cyc) && !bus.kill;
            exp_res  = (m_active && cyc == m_done_cyc) ? m_pend : m_result;
            chk("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
            chk("done", {31'b0, bus.done}, {31'b0, exp_done});
            chk("result", bus.result, exp_res);
            if (exp_busy) begin
                if (cyc == m_done_cyc) begin
                    m_result = m_pend;
                    m_active = 1'b0;
                end else if (bus.kill) begin
                    m_active = 1'b0;
                end
            end
            if (!exp_busy && bus.start && exp_mdu && !bus.kill) begin
                m_active   = 1'b1;
                m_acc      = cyc;
                m_done_cyc = cyc + ref_lat(bus.Funct3, bus.rs1, bus.rs2);
                m_pend     = ref_result(bus.Funct3, bus.rs1, bus.rs2);
            end
        end
    end

    task automatic scramble();
        bus.rs1    = $urandom;
        bus.rs2    = $urandom;
        bus.Funct3 = 3'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lit, input int exp_lat);
        int n;
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.Funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        n = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc - n;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected one at +%0d", name, exp_lat);
        end else begin
            chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({name, "_res"}, bus.result, exp_lit);
        end
    endtask

    initial begin
        int n;
        int lat;
        int ndone;
        logic [31:0] res_at_done;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.opcode = OPC_RTYPE;
        bus.Funct7 = F7_MULDIV;
        bus.Funct3 = 3'd0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        #1 rst = 1'b0;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_m", 3'd1, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, MUL_LAT);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33);
        run_op("div",    3'd4, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 33);
        run_op("rem",    3'd6, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 33);
        run_op("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         32'd5,         1);
        run_op("divu0",  3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);

        // Not an M-extension instruction, and start masked by kill in IDLE.
        @(posedge clk); #1;
        bus.Funct7 = 7'b0000000;
        bus.start  = 1'b1;
        bus.Funct3 = 3'd5;
        bus.rs1    = 32'd10;
        bus.rs2    = 32'd0;
        @(negedge clk);
        chk("nonmdu_is_mdu", {31'b0, bus.is_mdu}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.Funct7 = F7_MULDIV;
        bus.opcode = 7'b0010011;
        @(negedge clk);
        chk("badopc_busy", {31'b0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        bus.opcode = OPC_RTYPE;
        bus.kill   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(negedge clk);
        chk("nonmdu_busy", {31'b0, bus.busy}, 32'd0);
        chk("nonmdu_result", bus.result, 32'd2);

        // Second start in mid-CALC must not disturb the running divide.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Funct3 = 3'd5; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
        n = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.Funct3 = 3'd4; bus.rs1 = 32'd5; bus.rs2 = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0; lat = 0; res_at_done = '0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                lat = cyc - n;
                res_at_done = bus.result;
            end
        end
        chk("restart_ndone", 32'(ndone), 32'd1);
        chk("restart_lat", 32'(lat), 32'd33);
        chk("restart_res", res_at_done, 32'd14);

        // Kill at N+10, new accept at N+11 completes at N+44.
        run_op("remu2", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Funct3 = 3'd5; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
        n = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        bus.start = 1'b1; bus.Funct3 = 3'd6; bus.rs1 = 32'hFFFF_FF9C; bus.rs2 = 32'd7;
        @(negedge clk);
        chk("kill_idle", {31'b0, bus.busy}, 32'd0);
        chk("kill_result_kept", bus.result, 32'd2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        lat = 0;
        for (int k = 0; k < 45 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.done) lat = cyc - n;
            else if (k == 20) chk("kill_hold", bus.result, 32'd2);
        end
        chk("kill_done_cyc", 32'(lat), 32'd44);
        chk("kill_new_res", bus.result, 32'hFFFF_FFFE);

        // Asynchronous reset between edges mid-CALC.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Funct3 = 3'd5; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_result", bus.result, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);

        run_op("mul_after", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("divu_big",  3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
